// File: rtl/data_mem_lsu_if.sv
// Request/response bus between the EX/MEM stage (master) and the data
// memory load/store unit (slave).
//   MemRead/MemWrite : load / store request, held by the core until ReqReady
//   Funct3           : RV32I funct3 of the access
//   MemSum           : byte address
//   WriteData        : store data (low bits used per access size)
//   ReqReady         : LSU can accept a new request
//   RespValid        : one-cycle completion pulse
//   ReadData         : extended load result, held between responses
//   Err              : illegal access flag, valid with RespValid
interface data_mem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              MemRead;
  logic              MemWrite;
  logic [2:0]        Funct3;
  logic [ADDR_W-1:0] MemSum;
  logic [31:0]       WriteData;
  logic              ReqReady;
  logic              RespValid;
  logic [31:0]       ReadData;
  logic              Err;

  modport master (
    output MemRead, MemWrite, Funct3, MemSum, WriteData,
    input  ReqReady, RespValid, ReadData, Err
  );

  modport slave (
    input  MemRead, MemWrite, Funct3, MemSum, WriteData,
    output ReqReady, RespValid, ReadData, Err
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Word-organised data memory with an RV32I load/store unit in front of it.
// Handles LB/LH/LW/LBU/LHU and SB/SH/SW with byte-lane merging, sign/zero
// extension, misalignment and range checking. Each access takes
// WAIT_CYCLES+1 cycles in BUSY; the response is a one-cycle RespValid pulse.
// Ports:
//   clk   : clock, all state changes on rising edge
//   reset : synchronous active-high reset (restores memory image too)
//   bus   : data_mem_lsu_if slave modport (request/response signals)
module data_mem_lsu #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          ADDR_W      = 32,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] INIT_WORD0  = 32'h0A000000
) (
  input  logic         clk,
  input  logic         reset,
  data_mem_lsu_if.slave bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Range compare is done at least 32 bits wide so neither side truncates.
  localparam int CMP_W = (ADDR_W > 32) ? ADDR_W : 32;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [3:0]        count;
  logic              lat_rd;
  logic              lat_wr;
  logic [2:0]        lat_f3;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wd;
  logic              resp_valid;
  logic              err;
  logic [31:0]       read_data;
  logic [31:0]       mem [DEPTH_WORDS];

  logic [ADDR_W-3:0] word_idx;
  logic [1:0]        off;
  logic [IDX_W-1:0]  mem_idx;
  logic              in_range;
  logic              f3_bad;
  logic              misalign;
  logic              illegal;
  logic [31:0]       cur_word;
  logic [31:0]       shifted;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       load_val;
  logic [3:0]        lane_en;
  logic [31:0]       wd_rep;
  logic [31:0]       store_word;

  always_comb begin
    word_idx = lat_addr[ADDR_W-1:2];
    off      = lat_addr[1:0];
    mem_idx  = word_idx[IDX_W-1:0];
    in_range = CMP_W'(word_idx) < CMP_W'(DEPTH_WORDS);
    cur_word = in_range ? mem[mem_idx] : '0;

    // Stores only know sizes 0..2; loads additionally know the unsigned
    // byte/half forms 100/101.
    if (lat_wr) f3_bad = (lat_f3 > 3'd2);
    else        f3_bad = (lat_f3[1:0] == 2'b11) || (lat_f3 == 3'b110);
    misalign = ((lat_f3[1:0] == 2'b01) && off[0]) ||
               ((lat_f3[1:0] == 2'b10) && (off != 2'b00));
    illegal  = (lat_rd & lat_wr) | f3_bad | misalign | ~in_range;

    shifted = cur_word >> {off, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = off[1] ? cur_word[31:16] : cur_word[15:0];
    case (lat_f3)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_val = {24'd0, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b101:  load_val = {16'd0, half_v};
      default: load_val = cur_word;
    endcase

    // Replicate store data across lanes, then pick lanes by enable mask.
    case (lat_f3[1:0])
      2'b00: begin
        lane_en = 4'b0001 << off;
        wd_rep  = {4{lat_wd[7:0]}};
      end
      2'b01: begin
        lane_en = off[1] ? 4'b1100 : 4'b0011;
        wd_rep  = {2{lat_wd[15:0]}};
      end
      default: begin
        lane_en = 4'b1111;
        wd_rep  = lat_wd;
      end
    endcase
    store_word = cur_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (lane_en[i]) store_word[8*i +: 8] = wd_rep[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      resp_valid <= 1'b0;
      err        <= 1'b0;
      read_data  <= '0;
      lat_rd     <= 1'b0;
      lat_wr     <= 1'b0;
      lat_f3     <= '0;
      lat_addr   <= '0;
      lat_wd     <= '0;
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem[IDX_W'(i)] <= (i == 0) ? INIT_WORD0 : '0;
      end
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.MemRead || bus.MemWrite) begin
            lat_rd   <= bus.MemRead;
            lat_wr   <= bus.MemWrite;
            lat_f3   <= bus.Funct3;
            lat_addr <= bus.MemSum;
            lat_wd   <= bus.WriteData;
            count    <= 4'(WAIT_CYCLES);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            resp_valid <= 1'b1;
            err        <= illegal;
            state      <= IDLE;
            if (illegal) begin
              if (lat_rd) read_data <= '0;
            end else if (lat_rd) begin
              read_data <= load_val;
            end else begin
              mem[mem_idx] <= store_word;
            end
          end
        end
      endcase
    end
  end

  assign bus.ReqReady  = (state == IDLE);
  assign bus.RespValid = resp_valid;
  assign bus.ReadData  = read_data;
  assign bus.Err       = err;

endmodule

// File: tb/tb_data_mem_lsu.sv
module tb_data_mem_lsu;
  localparam int          DEPTH = 16;
  localparam int          AW    = 32;
  localparam logic [31:0] INIT  = 32'h0A000000;
  localparam int          NI    = 3;

  function automatic int wc_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst, mr, mw, rdy, rv, er;
  logic [2:0]    f3   [NI];
  logic [31:0]   addr [NI];
  logic [31:0]   wd   [NI];
  logic [31:0]   rdat [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    data_mem_lsu_if #(.ADDR_W(AW)) bus ();
    assign bus.MemRead   = mr[g];
    assign bus.MemWrite  = mw[g];
    assign bus.Funct3    = f3[g];
    assign bus.MemSum    = addr[g];
    assign bus.WriteData = wd[g];
    assign rdy[g]        = bus.ReqReady;
    assign rv[g]         = bus.RespValid;
    assign rdat[g]       = bus.ReadData;
    assign er[g]         = bus.Err;
    data_mem_lsu #(
      .DEPTH_WORDS(DEPTH),
      .ADDR_W(AW),
      .WAIT_CYCLES(wc_of(g)),
      .INIT_WORD0(INIT)
    ) dut (
      .clk(clk),
      .reset(rst[g]),
      .bus(bus)
    );
  end

  int checks = 0;
  int errors = 0;
  int last_wait;

  // Reference model: per-instance memory image and last response values.
  logic [31:0] mmem [NI][DEPTH];
  logic [31:0] m_rd [NI];
  logic        m_err [NI];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%h exp=%h", nm, k, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    for (int i = 0; i < DEPTH; i++) mmem[k][i] = '0;
    mmem[k][0] = INIT;
    m_rd[k]  = '0;
    m_err[k] = 1'b0;
  endtask

  task automatic model_apply(input int k, input bit rd, input bit wr, input logic [2:0] fn,
                             input logic [31:0] a, input logic [31:0] d);
    longint unsigned idx;
    int size, off;
    bit sgn, legal, load_ok;
    longint val;
    logic [31:0] w;
    idx = longint'(a) / 4;
    off = int'(a % 4);
    legal = 1; sgn = 0; size = 1; load_ok = 0;
    case (fn)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: begin size = 4; sgn = 0; end
      3'd4: begin size = 1; load_ok = 1; end
      3'd5: begin size = 2; load_ok = 1; end
      default: legal = 0;
    endcase
    if (rd && wr) legal = 0;
    if (wr && load_ok) legal = 0;
    if (off % size != 0) legal = 0;
    if (idx >= DEPTH) legal = 0;
    if (!legal) begin
      m_err[k] = 1'b1;
      if (rd) m_rd[k] = '0;
    end else if (rd) begin
      w = mmem[k][idx];
      val = 0;
      for (int i = 0; i < size; i++)
        val += longint'((w >> (8*(off+i))) & 32'hFF) << (8*i);
      if (sgn && size < 4 && val >= (longint'(1) << (8*size-1)))
        val -= longint'(1) << (8*size);
      m_rd[k]  = val[31:0];
      m_err[k] = 1'b0;
    end else begin
      w = mmem[k][idx];
      for (int i = 0; i < size; i++) begin
        w = (w & ~(32'hFF << (8*(off+i)))) | (((d >> (8*i)) & 32'hFF) << (8*(off+i)));
      end
      mmem[k][idx] = w;
      m_err[k] = 1'b0;
    end
  endtask

  task automatic release_in(input int k);
    mr[k] = 1'b0; mw[k] = 1'b0; f3[k] = '0; addr[k] = '0; wd[k] = '0;
  endtask

  // Call at a negedge. Drives the request, waits for acceptance, checks
  // latency/ReqReady and compares the response with the model. Returns at
  // the negedge of the RespValid cycle with inputs released.
  task automatic access(input int k, input bit rd, input bit wr, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] d, input bit hold,
                        input string nm);
    int waits, busy, j;
    bit got;
    mr[k] = rd; mw[k] = wr; f3[k] = fn; addr[k] = a; wd[k] = d;
    waits = 0;
    while (!rdy[k] && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!rdy[k]) begin
      checks++; errors++;
      $display("FAIL %s_accept_timeout inst=%0d", nm, k);
      release_in(k);
      return;
    end
    last_wait = waits;
    @(posedge clk);
    model_apply(k, rd, wr, fn, a, d);
    busy = 0; got = 0;
    for (j = 0; j < 50; j++) begin
      @(negedge clk);
      if (j == 0 && !hold) release_in(k);
      if (rv[k]) begin
        got = 1;
        break;
      end
      if (!rdy[k]) busy++;
    end
    release_in(k);
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_resp_timeout inst=%0d", nm, k);
      return;
    end
    chk({nm, "_latency"}, k, 32'(j), 32'(wc_of(k) + 1));
    chk({nm, "_busy_cycles"}, k, 32'(busy), 32'(wc_of(k) + 1));
    chk({nm, "_ready_at_resp"}, k, 32'(rdy[k]), 32'd1);
    chk({nm, "_rdata"}, k, rdat[k], m_rd[k]);
    chk({nm, "_err"}, k, 32'(er[k]), 32'(m_err[k]));
  endtask

  task automatic check_quiet(input int k, input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({nm, "_no_resp"}, k, 32'(rv[k]), 32'd0);
      chk({nm, "_ready"}, k, 32'(rdy[k]), 32'd1);
    end
  endtask

  task automatic reset_mid_access(input int k);
    @(negedge clk);
    mr[k] = 1'b0; mw[k] = 1'b1; f3[k] = 3'b010; addr[k] = 32'd12; wd[k] = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    release_in(k);
    chk("rst_mid_busy", k, 32'(rdy[k]), 32'd0);
    rst[k] = 1'b1;
    @(negedge clk);
    rst[k] = 1'b0;
    model_reset(k);
    chk("rst_mid_rv", k, 32'(rv[k]), 32'd0);
    chk("rst_mid_rdata", k, rdat[k], 32'd0);
    chk("rst_mid_err", k, 32'(er[k]), 32'd0);
    check_quiet(k, wc_of(k) + 3, "rst_mid");
    access(k, 1, 0, 3'b010, 32'd12, 0, 0, "rst_lw12");
    chk("rst_lw12_const", k, rdat[k], 32'd0);
    access(k, 1, 0, 3'b010, 32'd0, 0, 0, "rst_lw0");
    chk("rst_lw0_const", k, rdat[k], INIT);
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_err;
    bit          chk_rd;
  } vec_t;

  function automatic vec_t mk(input bit rd, input bit wr, input logic [2:0] fn, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] e, input bit ee, input bit c);
    vec_t v;
    v.rd = rd; v.wr = wr; v.fn = fn; v.a = a; v.d = d;
    v.exp_rd = e; v.exp_err = ee; v.chk_rd = c;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    rst = '1; mr = '0; mw = '0;
    for (int k = 0; k < NI; k++) begin
      f3[k] = '0; addr[k] = '0; wd[k] = '0;
    end

    tbl.push_back(mk(1, 0, 3'b000, 32'd3,  0,            32'h0000000A, 0, 1));
    tbl.push_back(mk(1, 0, 3'b010, 32'd0,  0,            32'h0A000000, 0, 1));
    tbl.push_back(mk(0, 1, 3'b010, 32'd8,  32'h8081F0F1, 32'h0A000000, 0, 1));
    tbl.push_back(mk(1, 0, 3'b000, 32'd8,  0,            32'hFFFFFFF1, 0, 1));
    tbl.push_back(mk(1, 0, 3'b100, 32'd9,  0,            32'h000000F0, 0, 1));
    tbl.push_back(mk(1, 0, 3'b001, 32'd10, 0,            32'hFFFF8081, 0, 1));
    tbl.push_back(mk(1, 0, 3'b101, 32'd10, 0,            32'h00008081, 0, 1));
    tbl.push_back(mk(1, 0, 3'b010, 32'd8,  0,            32'h8081F0F1, 0, 1));
    tbl.push_back(mk(0, 1, 3'b000, 32'd5,  32'h00000123, 32'h8081F0F1, 0, 1));
    tbl.push_back(mk(0, 1, 3'b001, 32'd6,  32'h0000BEEF, 32'h8081F0F1, 0, 1));
    tbl.push_back(mk(1, 0, 3'b010, 32'd4,  0,            32'hBEEF2300, 0, 1));
    tbl.push_back(mk(1, 0, 3'b010, 32'd6,  0,            32'h00000000, 1, 1));
    tbl.push_back(mk(0, 1, 3'b001, 32'd9,  32'h00001234, 32'h00000000, 1, 1));
    tbl.push_back(mk(1, 0, 3'b010, 32'd8,  0,            32'h8081F0F1, 0, 1));
    tbl.push_back(mk(1, 0, 3'b000, 32'(4*DEPTH), 0,      32'h00000000, 1, 1));
    tbl.push_back(mk(1, 1, 3'b010, 32'd8,  32'h00000000, 32'h00000000, 1, 0));
    tbl.push_back(mk(1, 0, 3'b010, 32'd8,  0,            32'h8081F0F1, 0, 1));
    tbl.push_back(mk(1, 0, 3'b011, 32'd0,  0,            32'h00000000, 1, 1));
    tbl.push_back(mk(0, 1, 3'b011, 32'd0,  32'hFFFFFFFF, 32'h00000000, 1, 1));
    tbl.push_back(mk(1, 0, 3'b010, 32'd0,  0,            32'h0A000000, 0, 1));

    repeat (2) @(negedge clk);
    rst = '0;
    for (int k = 0; k < NI; k++) model_reset(k);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("reset_ready", k, 32'(rdy[k]), 32'd1);
      chk("reset_rv", k, 32'(rv[k]), 32'd0);
      chk("reset_rdata", k, rdat[k], 32'd0);
      chk("reset_err", k, 32'(er[k]), 32'd0);
    end

    // Directed table on the WAIT_CYCLES=1 instance.
    foreach (tbl[i]) begin
      access(0, tbl[i].rd, tbl[i].wr, tbl[i].fn, tbl[i].a, tbl[i].d, 0, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_err_const", i), 0, 32'(er[0]), 32'(tbl[i].exp_err));
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata_const", i), 0, rdat[0], tbl[i].exp_rd);
    end

    // Latency corners on WAIT_CYCLES=0 and 3.
    for (int k = 1; k < NI; k++) begin
      @(negedge clk);
      access(k, 0, 1, 3'b010, 32'd4, 32'h11223344, 0, "b2b_sw");
      access(k, 1, 0, 3'b010, 32'd4, 0, 0, "b2b_lw");
      chk("b2b_no_idle", k, 32'(last_wait), 32'd0);
      chk("b2b_lw_const", k, rdat[k], 32'h11223344);
      access(k, 1, 0, 3'b001, 32'd6, 0, 1, "hold_lh");
      chk("hold_lh_const", k, rdat[k], 32'h00001122);
      check_quiet(k, wc_of(k) + 3, "hold");
      access(k, 0, 1, 3'b000, 32'd7, 32'hA5, 1, "hold_sb");
      check_quiet(k, 2, "hold_sb");
      access(k, 1, 0, 3'b010, 32'd4, 0, 0, "hold_sb_rb");
      chk("hold_sb_rb_const", k, rdat[k], 32'hA5223344);
    end

    // Reset during BUSY.
    access(0, 1, 0, 3'b010, 32'd0, 0, 0, "pre_rst");
    reset_mid_access(0);
    access(2, 1, 0, 3'b010, 32'd0, 0, 0, "pre_rst");
    reset_mid_access(2);

    // Randomized traffic against the model.
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 120; n++) begin
        int r;
        bit rd, wr, hold;
        logic [2:0] fn;
        logic [31:0] a;
        r = $urandom_range(0, 19);
        rd = (r < 10) || (r == 19);
        wr = (r >= 10);
        if ($urandom_range(0, 4) == 0) fn = 3'($urandom_range(0, 7));
        else if (rd) fn = 3'($urandom_range(0, 5) == 3 ? 4 : $urandom_range(0, 2));
        else fn = 3'($urandom_range(0, 2));
        r = $urandom_range(0, 19);
        if (r == 0) a = $urandom;
        else if (r < 3) a = 32'($urandom_range(4*DEPTH, 4*DEPTH + 15));
        else a = 32'($urandom_range(0, 4*DEPTH - 1));
        hold = ($urandom_range(0, 3) == 0);
        access(k, rd, wr, fn, a, $urandom, hold, "rnd");
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    // Final sweep of every word on each instance.
    for (int k = 0; k < NI; k++) begin
      for (int w = 0; w < DEPTH; w++) begin
        access(k, 1, 0, 3'b010, 32'(4*w), 0, 0, "sweep");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
